// File: rtl/card_board_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : card_pkg
// Description : Shared types and constants for the memory-game card renderer
//               front end (card states, board entry layout, screen limits).
// Revision    : 1.0 - initial release
// ============================================================================
package card_pkg;

  typedef enum logic [1:0] {
    HIDDEN  = 2'd0,
    SHOWN   = 2'd1,
    MATCHED = 2'd2
  } card_state_t;

  localparam int SYM_W    = 3;
  localparam int IDX_W    = 4;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // One board register-file entry.
  typedef struct packed {
    logic [SYM_W-1:0] symbol;
    card_state_t      state;
  } board_entry_t;

  // Leading edge of the n-th card along one axis, in 10-bit screen space.
  function automatic logic [9:0] span_start(input int origin, input int pitch,
                                            input logic [IDX_W-1:0] n);
    return 10'(origin) + 10'(n) * 10'(pitch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/card_board_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : card_board_scanner_if
// Description : Pixel, board-write and card-attribute signals exchanged
//               between the scanner and its producer/consumer logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface card_board_scanner_if;
  import card_pkg::*;

  // Pixel stream and frame timing
  logic              pix_valid;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              frame_start;
  // Board write port and cursor position from the game FSM
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [SYM_W-1:0]  wr_symbol;
  card_state_t       wr_state;
  logic [IDX_W-1:0]  cursor_idx;
  // Per-pixel card attributes towards the drawing logic
  logic              out_valid;
  logic              card_hit;
  logic [IDX_W-1:0]  card_idx;
  logic [9:0]        left;
  logic [9:0]        right;
  logic [9:0]        top;
  logic [9:0]        bot;
  logic [SYM_W-1:0]  symbol_sel;
  card_state_t       card_state;
  logic              cursor_hl;

  modport master (
    output pix_valid, x, y, frame_start,
    output wr_en, wr_idx, wr_symbol, wr_state, cursor_idx,
    input  out_valid, card_hit, card_idx, left, right, top, bot,
    input  symbol_sel, card_state, cursor_hl
  );

  modport slave (
    input  pix_valid, x, y, frame_start,
    input  wr_en, wr_idx, wr_symbol, wr_state, cursor_idx,
    output out_valid, card_hit, card_idx, left, right, top, bot,
    output symbol_sel, card_state, cursor_hl
  );

endinterface
`default_nettype wire

// File: rtl/card_board_scanner_locator.sv
`default_nettype none
// ============================================================================
// Module      : card_locator
// Description : Combinational pixel-to-card mapping. Reports whether a screen
//               coordinate falls inside a card rectangle and which row/column.
// Revision    : 1.0 - initial release
// ============================================================================
module card_locator
  import card_pkg::*;
#(
  parameter int COLS     = 4,
  parameter int ROWS     = 4,
  parameter int CARD_W   = 50,
  parameter int CARD_H   = 70,
  parameter int GAP      = 10,
  parameter int ORIGIN_X = 60,
  parameter int ORIGIN_Y = 40
) (
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  output logic             hit,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col
);

  localparam int PITCH_X = CARD_W + GAP;
  localparam int PITCH_Y = CARD_H + GAP;

  logic col_hit;
  logic row_hit;

  // Scan every column span; rectangles are inclusive on both edges.
  always_comb begin
    col_hit = 1'b0;
    col     = '0;
    for (int c = 0; c < COLS; c++) begin
      if (x >= 10'(ORIGIN_X + c * PITCH_X) &&
          x <= 10'(ORIGIN_X + c * PITCH_X + CARD_W - 1)) begin
        col_hit = 1'b1;
        col     = IDX_W'(c);
      end
    end
  end

  // Scan every row span.
  always_comb begin
    row_hit = 1'b0;
    row     = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (y >= 10'(ORIGIN_Y + r * PITCH_Y) &&
          y <= 10'(ORIGIN_Y + r * PITCH_Y + CARD_H - 1)) begin
        row_hit = 1'b1;
        row     = IDX_W'(r);
      end
    end
  end

  assign hit = col_hit & row_hit;

endmodule
`default_nettype wire

// File: rtl/card_board_scanner.sv
`default_nettype none
// ============================================================================
// Module      : card_board_scanner
// Description : Two-stage pixel pipeline that finds the card under each pixel,
//               reads its symbol/state from the board register file and emits
//               card bounds plus a blinking cursor highlight.
// Revision    : 1.0 - initial release
// ============================================================================
module card_board_scanner
  import card_pkg::*;
#(
  parameter int COLS         = 4,
  parameter int ROWS         = 4,
  parameter int CARD_W       = 50,
  parameter int CARD_H       = 70,
  parameter int GAP          = 10,
  parameter int ORIGIN_X     = 60,
  parameter int ORIGIN_Y     = 40,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  card_board_scanner_if.slave bus
);

  localparam int N_CARDS = ROWS * COLS;
  localparam int N_SLOTS = 1 << IDX_W;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int GRID_R  = ORIGIN_X + (COLS - 1) * (CARD_W + GAP) + CARD_W;
  localparam int GRID_B  = ORIGIN_Y + (ROWS - 1) * (CARD_H + GAP) + CARD_H;

  // The grid must fit the index space and stay on the visible screen.
  if (N_CARDS > N_SLOTS || GRID_R > H_ACTIVE || GRID_B > V_ACTIVE ||
      BLINK_FRAMES < 1) begin : g_param_check
    $error("card_board_scanner: grid parameters out of range");
  end

  // --------------------------------------------------------------------------
  // Stage 1: coordinate to card position
  // --------------------------------------------------------------------------
  logic             loc_hit;
  logic [IDX_W-1:0] loc_row;
  logic [IDX_W-1:0] loc_col;

  card_locator #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .CARD_W   (CARD_W),
    .CARD_H   (CARD_H),
    .GAP      (GAP),
    .ORIGIN_X (ORIGIN_X),
    .ORIGIN_Y (ORIGIN_Y)
  ) u_locator (
    .x   (bus.x),
    .y   (bus.y),
    .hit (loc_hit),
    .row (loc_row),
    .col (loc_col)
  );

  logic             s1_valid_q, s1_valid_d;
  logic             s1_hit_q,   s1_hit_d;
  logic [IDX_W-1:0] s1_row_q,   s1_row_d;
  logic [IDX_W-1:0] s1_col_q,   s1_col_d;

  // Stage-1 next state: position is only kept for valid hits.
  always_comb begin
    s1_valid_d = bus.pix_valid;
    s1_hit_d   = bus.pix_valid & loc_hit;
    s1_row_d   = s1_hit_d ? loc_row : '0;
    s1_col_d   = s1_hit_d ? loc_col : '0;
  end

  // --------------------------------------------------------------------------
  // Board register file and blink timer
  // --------------------------------------------------------------------------
  board_entry_t board_q [N_SLOTS];
  board_entry_t board_d [N_SLOTS];

  // Single write port; indices beyond the populated grid are dropped.
  always_comb begin
    board_d = board_q;
    if (bus.wr_en && (32'(bus.wr_idx) < N_CARDS)) begin
      board_d[bus.wr_idx] = '{symbol: bus.wr_symbol, state: bus.wr_state};
    end
  end

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q,     phase_d;

  // Count frames; toggle the blink phase each time the count wraps.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (bus.frame_start) begin
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: board lookup, geometry and highlight
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] s1_idx;
  assign s1_idx = IDX_W'(32'(s1_row_q) * COLS + 32'(s1_col_q));

  logic             out_valid_q,  out_valid_d;
  logic             card_hit_q,   card_hit_d;
  logic [IDX_W-1:0] card_idx_q,   card_idx_d;
  logic [9:0]       left_q,       left_d;
  logic [9:0]       right_q,      right_d;
  logic [9:0]       top_q,        top_d;
  logic [9:0]       bot_q,        bot_d;
  logic [SYM_W-1:0] symbol_sel_q, symbol_sel_d;
  card_state_t      card_state_q, card_state_d;
  logic             cursor_hl_q,  cursor_hl_d;

  // Misses and invalid pixels produce all-zero attributes. The board is read
  // from the current register contents, so a same-cycle write is not seen.
  always_comb begin
    out_valid_d  = s1_valid_q;
    card_hit_d   = 1'b0;
    card_idx_d   = '0;
    left_d       = '0;
    right_d      = '0;
    top_d        = '0;
    bot_d        = '0;
    symbol_sel_d = '0;
    card_state_d = HIDDEN;
    cursor_hl_d  = 1'b0;
    if (s1_valid_q && s1_hit_q) begin
      card_hit_d   = 1'b1;
      card_idx_d   = s1_idx;
      left_d       = span_start(ORIGIN_X, CARD_W + GAP, s1_col_q);
      right_d      = left_d + 10'(CARD_W - 1);
      top_d        = span_start(ORIGIN_Y, CARD_H + GAP, s1_row_q);
      bot_d        = top_d + 10'(CARD_H - 1);
      symbol_sel_d = board_q[s1_idx].symbol;
      card_state_d = board_q[s1_idx].state;
      cursor_hl_d  = (s1_idx == bus.cursor_idx) & phase_q;
    end
  end

  // All state flops; reset clears the pipeline, board and blink timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_hit_q     <= 1'b0;
      s1_row_q     <= '0;
      s1_col_q     <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        board_q[i] <= '{symbol: '0, state: HIDDEN};
      end
      blink_cnt_q  <= '0;
      phase_q      <= 1'b1;
      out_valid_q  <= 1'b0;
      card_hit_q   <= 1'b0;
      card_idx_q   <= '0;
      left_q       <= '0;
      right_q      <= '0;
      top_q        <= '0;
      bot_q        <= '0;
      symbol_sel_q <= '0;
      card_state_q <= HIDDEN;
      cursor_hl_q  <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_hit_q     <= s1_hit_d;
      s1_row_q     <= s1_row_d;
      s1_col_q     <= s1_col_d;
      board_q      <= board_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      out_valid_q  <= out_valid_d;
      card_hit_q   <= card_hit_d;
      card_idx_q   <= card_idx_d;
      left_q       <= left_d;
      right_q      <= right_d;
      top_q        <= top_d;
      bot_q        <= bot_d;
      symbol_sel_q <= symbol_sel_d;
      card_state_q <= card_state_d;
      cursor_hl_q  <= cursor_hl_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.card_hit   = card_hit_q;
  assign bus.card_idx   = card_idx_q;
  assign bus.left       = left_q;
  assign bus.right      = right_q;
  assign bus.top        = top_q;
  assign bus.bot        = bot_q;
  assign bus.symbol_sel = symbol_sel_q;
  assign bus.card_state = card_state_q;
  assign bus.cursor_hl  = cursor_hl_q;

endmodule
`default_nettype wire
